// File: rtl/sa_step_sequencer_pkg.sv
// Shared definitions for the systolic-array step sequencer: FSM state encoding,
// operand-mux select codes and the default final step of a pass.
package sa_step_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } seq_state_e;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;

    localparam int DEFAULT_LAST_STEP = 8;

endpackage

// File: rtl/sa_sel_map.sv
// Combinational map from step count to the 3:1 operand-mux select.
module sa_sel_map
    import sa_step_sequencer_pkg::*;
(
    input  logic [3:0] cnt_i,
    output logic [1:0] sel_o
);

    // Counts 9..15 never occur in a pass but still map to a defined select
    always_comb begin
        sel_o = SEL_A;
        case (cnt_i)
            4'd0, 4'd1, 4'd3: sel_o = SEL_A;
            4'd2, 4'd4, 4'd6: sel_o = SEL_B;
            4'd5, 4'd7, 4'd8: sel_o = SEL_C;
            default:          sel_o = SEL_A;
        endcase
    end

endmodule

// File: rtl/sa_step_sequencer.sv
// Step/pass sequencer for the systolic array: walks cnt through 0..LAST_STEP for
// NUM_PASSES passes per start, freezing on stall, and pulses done at the end.
module sa_step_sequencer
    import sa_step_sequencer_pkg::*;
#(
    parameter int LAST_STEP  = DEFAULT_LAST_STEP,
    parameter int NUM_PASSES = 1,
    parameter int PASS_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              clear,
    output logic [3:0]        cnt,
    output logic [1:0]        sel,
    output logic              step_valid,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0]        LastCnt  = 4'(LAST_STEP);
    localparam logic [PASS_W-1:0] LastPass = PASS_W'(NUM_PASSES - 1);

    seq_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [PASS_W-1:0] pass_q, pass_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    // The last step of a non-final pass wraps straight into step 0 of the next pass
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d  = 4'd0;
                pass_d = '0;
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (cnt_q < LastCnt) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (pass_q < LastPass) begin
                        cnt_d  = 4'd0;
                        pass_d = pass_q + PASS_W'(1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                pass_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                pass_d  = '0;
            end
        endcase
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            pass_d  = '0;
        end
    end

    assign cnt        = cnt_q;
    assign pass_idx   = pass_q;
    assign busy       = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign step_valid = (state_q == ST_RUN) && !stall;

    sa_sel_map u_sel_map (
        .cnt_i (cnt_q),
        .sel_o (sel)
    );

endmodule

// File: tb/tb_sa_step_sequencer.sv
// Self-checking bench: a single-pass and a three-pass sequencer share one stimulus
// stream and are compared every cycle against a step-index model plus literal checks.
module tb_sa_step_sequencer;

    localparam int STEPS = 9;

    logic clk = 1'b0;
    logic reset, start, stall, clear;

    logic [3:0] cnt1, cnt3;
    logic [1:0] sel1, sel3;
    logic       stepValid1, stepValid3;
    logic [3:0] passIdx1, passIdx3;
    logic       busy1, busy3, done1, done3;

    int checks   = 0;
    int failures = 0;

    int mMode[2];
    int mK[2];
    int numPasses[2];
    int selTable[STEPS];
    bit modelValid = 0;

    always #5 clk = ~clk;

    sa_step_sequencer #(.LAST_STEP(8), .NUM_PASSES(1), .PASS_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .clear(clear),
        .cnt(cnt1), .sel(sel1), .step_valid(stepValid1), .pass_idx(passIdx1),
        .busy(busy1), .done(done1)
    );

    sa_step_sequencer #(.LAST_STEP(8), .NUM_PASSES(3), .PASS_W(4)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .clear(clear),
        .cnt(cnt3), .sel(sel3), .step_valid(stepValid3), .pass_idx(passIdx3),
        .busy(busy3), .done(done3)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit startV, input bit stallV, input bit clearV);
        start = startV;
        stall = stallV;
        clear = clearV;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Model: mode 0 idle, 1 run, 2 done; mK is the linear step index within the run
    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (reset || clear) begin
                mMode[n] = 0;
                mK[n]    = 0;
            end else if (mMode[n] == 0) begin
                if (start) begin
                    mMode[n] = 1;
                    mK[n]    = 0;
                end
            end else if (mMode[n] == 1) begin
                if (!stall) begin
                    if (mK[n] == STEPS * numPasses[n] - 1) mMode[n] = 2;
                    else mK[n] = mK[n] + 1;
                end
            end else begin
                mMode[n] = 0;
                mK[n]    = 0;
            end
        end
        modelValid = 1;
    end

    task automatic compareDut(input int n, input string tag, input int c, input int s,
                              input int sv, input int p, input int b, input int d);
        int eCnt, ePass;
        eCnt  = (mMode[n] == 0) ? 0 : mK[n] % STEPS;
        ePass = (mMode[n] == 0) ? 0 : mK[n] / STEPS;
        checkOutput({tag, ".cnt"}, c, eCnt);
        checkOutput({tag, ".sel"}, s, selTable[eCnt]);
        checkOutput({tag, ".step_valid"}, sv, (mMode[n] == 1 && !stall) ? 1 : 0);
        checkOutput({tag, ".pass_idx"}, p, ePass);
        checkOutput({tag, ".busy"}, b, (mMode[n] != 0) ? 1 : 0);
        checkOutput({tag, ".done"}, d, (mMode[n] == 2) ? 1 : 0);
    endtask

    always @(negedge clk) begin
        if (modelValid) begin
            compareDut(0, "p1", cnt1, sel1, stepValid1, passIdx1, busy1, done1);
            compareDut(1, "p3", cnt3, sel3, stepValid3, passIdx3, busy3, done3);
        end
    end

    initial begin
        int first1, first3, count1, count3;
        int selExp[STEPS];
        numPasses = '{1, 3};
        selTable  = '{0, 0, 1, 0, 1, 2, 1, 2, 2};
        selExp    = '{0, 0, 1, 0, 1, 2, 1, 2, 2};

        // Reset for two cycles, then idle with stall toggling (stall ignored in IDLE)
        reset = 1'b1;
        applyStimulus(0, 0, 0);
        nextCycle();
        nextCycle();
        checkOutput("reset.cnt", cnt1, 0);
        checkOutput("reset.sel", sel1, 0);
        checkOutput("reset.busy", busy1, 0);
        checkOutput("reset.done", done3, 0);
        checkOutput("reset.step_valid", stepValid3, 0);
        reset = 1'b0;
        applyStimulus(0, 1, 0);
        nextCycle();
        nextCycle();
        checkOutput("idle.busy", busy1, 0);
        checkOutput("idle.cnt", cnt3, 0);

        // Single pass: cnt 0..8 on cycles 1..9, done on 10, idle on 11
        applyStimulus(1, 0, 0);
        nextCycle();
        for (int i = 0; i < STEPS; i++) begin
            applyStimulus(0, 0, 0);
            checkOutput("single.cnt", cnt1, i);
            checkOutput("single.sel", sel1, selExp[i]);
            nextCycle();
        end
        checkOutput("single.done", done1, 1);
        nextCycle();
        checkOutput("single.busy_low", busy1, 0);
        checkOutput("single.done_low", done1, 0);
        applyStimulus(0, 0, 1);
        nextCycle();

        // Stall for three cycles while cnt=4: every done slips by three cycles
        applyStimulus(1, 0, 0);
        nextCycle();
        first1 = -1; first3 = -1; count3 = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            applyStimulus(0, (cyc >= 5 && cyc <= 7), 0);
            if (cyc >= 5 && cyc <= 7) begin
                checkOutput("stall.cnt", cnt1, 4);
                checkOutput("stall.sel", sel1, 1);
                checkOutput("stall.step_valid", stepValid1, 0);
            end
            if (done1 && first1 < 0) first1 = cyc;
            if (done3) begin
                count3++;
                if (first3 < 0) first3 = cyc;
            end
            nextCycle();
        end
        checkOutput("stall.done1_cycle", first1, 13);
        checkOutput("stall.done3_cycle", first3, 31);
        checkOutput("stall.done3_pulses", count3, 1);

        // Three passes back to back with no bubble, a single done after 27 steps
        applyStimulus(1, 0, 0);
        nextCycle();
        first3 = -1; count3 = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            applyStimulus(0, 0, 0);
            if (cyc == 9)  begin checkOutput("multi.c9.cnt", cnt3, 8); checkOutput("multi.c9.pass", passIdx3, 0); end
            if (cyc == 10) begin checkOutput("multi.c10.cnt", cnt3, 0); checkOutput("multi.c10.pass", passIdx3, 1); end
            if (cyc == 19) begin checkOutput("multi.c19.cnt", cnt3, 0); checkOutput("multi.c19.pass", passIdx3, 2); end
            if (cyc == 27) begin checkOutput("multi.c27.cnt", cnt3, 8); checkOutput("multi.c27.sel", sel3, 2); end
            if (done3) begin
                count3++;
                if (first3 < 0) first3 = cyc;
            end
            nextCycle();
        end
        checkOutput("multi.done_cycle", first3, 28);
        checkOutput("multi.done_pulses", count3, 1);

        // Clear at cnt=6 aborts without done; a start during RUN is ignored
        applyStimulus(1, 0, 0);
        nextCycle();
        count1 = 0; count3 = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            applyStimulus(cyc == 3, 0, cyc == 7);
            if (cyc == 4) checkOutput("clear.start_ignored", cnt1, 3);
            if (cyc == 7) checkOutput("clear.at_cnt", cnt1, 6);
            if (cyc == 8) begin
                checkOutput("clear.busy1", busy1, 0);
                checkOutput("clear.cnt1", cnt1, 0);
                checkOutput("clear.busy3", busy3, 0);
            end
            count1 += done1;
            count3 += done3;
            nextCycle();
        end
        checkOutput("clear.done1_pulses", count1, 0);
        checkOutput("clear.done3_pulses", count3, 0);

        // Clear coinciding with the final step suppresses done
        applyStimulus(1, 0, 0);
        nextCycle();
        count1 = 0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            applyStimulus(0, 0, cyc == 9);
            if (cyc == 9)  checkOutput("edge.final_cnt", cnt1, 8);
            if (cyc == 10) checkOutput("edge.busy_after_clear", busy1, 0);
            count1 += done1;
            nextCycle();
        end
        checkOutput("edge.done_suppressed", count1, 0);

        // Start in the DONE cycle is ignored; start in the next cycle is accepted
        applyStimulus(1, 0, 0);
        nextCycle();
        for (int cyc = 1; cyc <= 15; cyc++) begin
            applyStimulus(cyc == 10 || cyc == 11, 0, 0);
            if (cyc == 10) checkOutput("restart.done", done1, 1);
            if (cyc == 11) checkOutput("restart.ignored_in_done", busy1, 0);
            if (cyc == 12) begin
                checkOutput("restart.busy", busy1, 1);
                checkOutput("restart.cnt", cnt1, 0);
            end
            if (cyc == 13) checkOutput("restart.cnt_next", cnt1, 1);
            nextCycle();
        end
        applyStimulus(0, 0, 1);
        nextCycle();
        applyStimulus(0, 0, 0);
        nextCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
